// File: rtl/countdown_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : countdown_timer                                              |
// | Description : Loadable down-counter with a one-cycle terminal-count pulse, |
// |               one-shot or periodic (auto-reload) operation.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module countdown_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             periodic,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             tc
);

  localparam logic [WIDTH-1:0] c_zero = '0;
  localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic             r_periodic;
  logic             r_busy;
  logic             r_tc;

  wire w_load_ok = load && (load_val != c_zero);
  wire w_term    = (r_count == c_one);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_count    <= c_zero;
      r_reload   <= c_zero;
      r_periodic <= 1'b0;
      r_busy     <= 1'b0;
      r_tc       <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      // Any load request, even a rejected zero load, suppresses counting this edge.
      if (load) begin
        if (w_load_ok) begin
          r_count    <= load_val;
          r_reload   <= load_val;
          r_periodic <= periodic;
          r_state    <= S_RUN;
          r_busy     <= 1'b1;
        end
      end else begin
        case (r_state)
          S_RUN: begin
            if (en) begin
              if (w_term) begin
                r_tc <= 1'b1;
                if (r_periodic) begin
                  r_count <= r_reload;
                end else begin
                  r_count <= c_zero;
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                end
              end else begin
                r_count <= r_count - c_one;
              end
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out  = r_count;
  assign busy = r_busy;
  assign tc   = r_tc;

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_countdown_timer                                           |
// | Description : Directed vector bench for countdown_timer.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_countdown_timer;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             periodic;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             tc;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic             ld;
    logic [WIDTH-1:0] lv;
    logic             per;
    logic             en;
    logic [WIDTH-1:0] eo;
    logic             eb;
    logic             et;
  } vec_t;

  vec_t vecs[$];

  countdown_timer #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .periodic (periodic),
    .out      (out),
    .busy     (busy),
    .tc       (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [WIDTH-1:0] eo,
                     input logic eb, input logic et);
    checks++;
    if (out !== eo || busy !== eb || tc !== et) begin
      errors++;
      $display("FAIL %s: got out=%0d busy=%b tc=%b, want out=%0d busy=%b tc=%b",
               name, out, busy, tc, eo, eb, et);
    end
  endtask

  task automatic add(input logic ld, input int lv, input logic per, input logic e,
                     input int eo, input logic eb, input logic et);
    vec_t v;
    v.ld = ld; v.lv = WIDTH'(lv); v.per = per; v.en = e;
    v.eo = WIDTH'(eo); v.eb = eb; v.et = et;
    vecs.push_back(v);
  endtask

  // Drive at negedge, let one rising edge pass, sample 1 time unit later.
  task automatic step(input logic ld, input logic [WIDTH-1:0] lv,
                      input logic per, input logic e);
    @(negedge clk);
    load = ld; load_val = lv; periodic = per; en = e;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int tc_count;
    logic [WIDTH-1:0] exp_o;
    logic exp_t;

    rst = 1'b0; en = 1'b0; load = 1'b0; load_val = '0; periodic = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    // zero load and enable while idle are ignored
    add(1, 0, 1, 0,   0, 0, 0);
    add(0, 0, 0, 1,   0, 0, 0);
    // one-shot from 5
    add(1, 5, 0, 0,   5, 1, 0);
    add(0, 0, 0, 1,   4, 1, 0);
    add(0, 0, 0, 1,   3, 1, 0);
    add(0, 0, 0, 1,   2, 1, 0);
    add(0, 0, 0, 1,   1, 1, 0);
    add(0, 0, 0, 1,   0, 0, 1);
    add(0, 0, 0, 1,   0, 0, 0);
    add(0, 0, 0, 1,   0, 0, 0);
    // hold with en low, then count out from 4
    add(1, 4, 0, 0,   4, 1, 0);
    add(0, 0, 0, 0,   4, 1, 0);
    add(0, 0, 0, 0,   4, 1, 0);
    add(0, 0, 0, 0,   4, 1, 0);
    add(0, 0, 0, 1,   3, 1, 0);
    add(0, 0, 0, 1,   2, 1, 0);
    add(0, 0, 0, 1,   1, 1, 0);
    add(0, 0, 0, 1,   0, 0, 1);
    // reload on the terminal edge wins over tc
    add(1, 2, 0, 0,   2, 1, 0);
    add(0, 0, 0, 1,   1, 1, 0);
    add(1, 9, 0, 1,   9, 1, 0);
    add(0, 0, 0, 1,   8, 1, 0);
    add(0, 0, 0, 1,   7, 1, 0);
    // zero load while running at 7: ignored, counting resumes from 7
    add(1, 0, 1, 1,   7, 1, 0);
    add(0, 0, 0, 1,   6, 1, 0);
    // zero load must not change the periodic mode
    add(1, 2, 1, 0,   2, 1, 0);
    add(1, 0, 0, 1,   2, 1, 0);
    add(0, 0, 0, 1,   1, 1, 0);
    add(0, 0, 0, 1,   2, 1, 1);
    add(0, 0, 0, 1,   1, 1, 0);
    // periodic reload of 1: tc every enabled cycle
    add(1, 1, 1, 0,   1, 1, 0);
    add(0, 0, 0, 1,   1, 1, 1);
    add(0, 0, 0, 1,   1, 1, 1);
    add(0, 0, 0, 0,   1, 1, 0);

    foreach (vecs[i]) begin
      step(vecs[i].ld, vecs[i].lv, vecs[i].per, vecs[i].en);
      chk($sformatf("vec%0d", i), vecs[i].eo, vecs[i].eb, vecs[i].et);
    end

    // asynchronous reset mid-cycle while running, no clock edge
    @(negedge clk);
    en = 1'b0; load = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset", 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    // periodic reload of 3 over 20 enabled cycles
    step(1'b1, WIDTH'(3), 1'b1, 1'b0);
    chk("per_load", 3, 1, 0);
    tc_count = 0;
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, '0, 1'b0, 1'b1);
      exp_t = (k % 3 == 0);
      exp_o = exp_t ? WIDTH'(3) : WIDTH'(3 - (k % 3));
      if (tc === 1'b1) tc_count++;
      chk($sformatf("per_cyc%0d", k), exp_o, 1'b1, exp_t);
    end
    checks++;
    if (tc_count != 6) begin
      errors++;
      $display("FAIL per_tc_count: got %0d pulses, want 6", tc_count);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
